// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing the ALU divide/remainder engine between two
// valid/ready requesters; holds the ALU inputs for the whole operation and returns the result.
module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 63
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req0_valid,
    input  logic [4:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             req0_done,
    output logic [WIDTH-1:0] req0_result,
    output logic             req0_err,
    input  logic             req1_valid,
    input  logic [4:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             req1_done,
    output logic [WIDTH-1:0] req1_result,
    output logic             req1_err,
    output logic [4:0]       alu_aluc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_div_ready,
    output logic             busy,
    output logic             timeout_sticky
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic             last_q, owner_q, sticky_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res0_q, res1_q;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             done0_q, done1_q, err0_q, err1_q;

    logic             is_idle, grant_id, accept, sel_legal, timed_out, drive;
    logic [4:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             fin, fin_id, fin_err;
    logic [WIDTH-1:0] fin_val;

    assign is_idle    = (state_q == IDLE);
    // With both requests pending, the side that did not win last time takes the grant.
    assign grant_id   = req1_valid & (~req0_valid | ~last_q);
    assign accept     = is_idle & (req0_valid | req1_valid);
    assign req0_ready = is_idle & req0_valid & ~grant_id;
    assign req1_ready = is_idle & grant_id;

    assign sel_op     = grant_id ? req1_op : req0_op;
    assign sel_a      = grant_id ? req1_a  : req0_a;
    assign sel_b      = grant_id ? req1_b  : req0_b;
    assign sel_legal  = (sel_op[4:2] == 3'b101);

    assign wait_cnt_d = wait_cnt_q + CNT_W'(1);
    assign timed_out  = (wait_cnt_d == CNT_W'(TIMEOUT));

    // Outside ISSUE/WAIT the ALU sees ADD 0,0 so it cannot restart after its DONE cycle.
    assign drive      = (state_q == ISSUE) || (state_q == WAIT);
    assign alu_aluc   = drive ? op_q : 5'd0;
    assign alu_a      = drive ? a_q  : '0;
    assign alu_b      = drive ? b_q  : '0;

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        fin     = 1'b0;
        fin_id  = owner_q;
        fin_err = 1'b0;
        fin_val = '0;
        if (accept && !sel_legal) begin
            fin     = 1'b1;
            fin_id  = grant_id;
            fin_err = 1'b1;
        end else if (state_q == WAIT) begin
            if (alu_div_ready) begin
                fin     = 1'b1;
                fin_val = alu_result;
            end else if (timed_out) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                fin_val = '1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            op_q       <= 5'd0;
            a_q        <= '0;
            b_q        <= '0;
            wait_cnt_q <= '0;
            res0_q     <= '0;
            res1_q     <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            done0_q <= fin & ~fin_id;
            done1_q <= fin & fin_id;
            err0_q  <= fin & ~fin_id & fin_err;
            err1_q  <= fin & fin_id & fin_err;
            if (fin && !fin_id) res0_q <= fin_val;
            if (fin && fin_id)  res1_q <= fin_val;
            if (state_q == WAIT && !alu_div_ready && timed_out) sticky_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q    <= grant_id;
                        last_q     <= grant_id;
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        wait_cnt_q <= '0;
                        state_q    <= sel_legal ? ISSUE : RESP;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (fin) state_q    <= RESP;
                    else     wait_cnt_q <= wait_cnt_d;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_done      = done0_q;
    assign req1_done      = done1_q;
    assign req0_err       = err0_q;
    assign req1_err       = err1_q;
    assign req0_result    = res0_q;
    assign req1_result    = res1_q;
    assign busy           = ~is_idle;
    assign timeout_sticky = sticky_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a cycle-accurate stub of the ALU divide engine.
module tb_div_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
    logic [31:0] req0_result, req1_result;
    logic [4:0]  alu_aluc;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_div_ready, busy, timeout_sticky;

    int checks = 0;
    int failures = 0;
    logic aluc_seen, other_done_seen, ready_seen;

    always #5 CLK = ~CLK;

    div_arbiter #(.WIDTH(32), .TIMEOUT(63)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_result(req0_result), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_result(req1_result), .req1_err(req1_err),
        .alu_aluc(alu_aluc), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_div_ready(alu_div_ready), .busy(busy), .timeout_sticky(timeout_sticky)
    );

    // Stub ALU: samples A/B/aluc when idle, BUSY 33 cycles (1 for special cases), then divReady.
    logic [5:0]  alu_rem;
    logic [31:0] alu_res_q;
    logic        alu_stall = 1'b0;

    function automatic logic [31:0] alu_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'd20:   alu_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            5'd21:   alu_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22:   alu_div = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: alu_div = (b == 0) ? a : a % b;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            alu_rem   <= 6'd0;
            alu_res_q <= 32'd0;
        end else if (alu_rem != 6'd0) begin
            alu_rem <= alu_rem - 6'd1;
        end else if (alu_aluc >= 5'd20 && alu_aluc <= 5'd23) begin
            alu_rem   <= (alu_b == 0 || (!alu_aluc[0] && alu_a == 32'h8000_0000 && alu_b == 32'hFFFF_FFFF)) ? 6'd2 : 6'd34;
            alu_res_q <= alu_div(alu_aluc, alu_a, alu_b);
        end
    end
    assign alu_div_ready = (alu_rem == 6'd1) && !alu_stall;
    assign alu_result    = alu_res_q;

    // Presents one request at a negedge (T0), reports ready, drops valid after the accept edge.
    task automatic issue(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic rdy);
        @(negedge CLK);
        if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        #1 rdy = (id == 0) ? req0_ready : req1_ready;
        @(posedge CLK);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Counts cycles after T0 until the requester's done; returns max+1 if it never comes.
    task automatic wait_done(input int id, input int max, output int cycles);
        cycles = max + 1;
        aluc_seen = 1'b0;
        other_done_seen = 1'b0;
        ready_seen = 1'b0;
        for (int k = 1; k <= max; k++) begin
            @(negedge CLK);
            if (alu_aluc != 5'd0) aluc_seen = 1'b1;
            if (req0_ready || req1_ready) ready_seen = 1'b1;
            if ((id == 0) ? req1_done : req0_done) other_done_seen = 1'b1;
            if ((id == 0) ? req0_done : req1_done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, req0_done, req1_done, req0_err, req1_err, timeout_sticky} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000", {busy, req0_done, req1_done, req0_err, req1_err, timeout_sticky});
        end
        checks++;
        if ({req0_result, req1_result, alu_aluc, alu_a, alu_b} !== '0) begin
            failures++; $display("FAIL reset_data r0=%h r1=%h aluc=%0d a=%h b=%h want all 0", req0_result, req1_result, alu_aluc, alu_a, alu_b);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b want=000", {busy, req0_ready, req1_ready});
        end
    endtask

    task automatic test_div_signed();
        logic rdy; int cyc;
        issue(0, 5'd20, 32'hFFFF_FFF9, 32'd2, rdy);
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL div_ready got=%b want=1", rdy); end
        wait_done(0, 80, cyc);
        checks++;
        if (cyc != 36) begin failures++; $display("FAIL div_latency got=%0d want=36", cyc); end
        checks++;
        if (req0_result !== 32'hFFFF_FFFD || req0_err !== 1'b0) begin
            failures++; $display("FAIL div_result got=%h err=%b want=fffffffd err=0", req0_result, req0_err);
        end
        checks++;
        if (ready_seen !== 1'b0) begin failures++; $display("FAIL ready_while_busy got=1 want=0"); end
        @(negedge CLK);
        checks++;
        if ({req0_done, req0_err, busy} !== 3'b0 || req0_result !== 32'hFFFF_FFFD) begin
            failures++; $display("FAIL after_done done=%b err=%b busy=%b res=%h want 0 0 0 fffffffd", req0_done, req0_err, busy, req0_result);
        end
    endtask

    task automatic test_div_by_zero();
        logic rdy; int cyc;
        issue(0, 5'd23, 32'd7, 32'd0, rdy);
        wait_done(0, 80, cyc);
        checks++;
        if (cyc != 4 || req0_result !== 32'd7) begin
            failures++; $display("FAIL remu_by_zero cyc=%0d res=%h want cyc=4 res=00000007", cyc, req0_result);
        end
        issue(0, 5'd21, 32'd7, 32'd0, rdy);
        wait_done(0, 80, cyc);
        checks++;
        if (cyc != 4 || req0_result !== 32'hFFFF_FFFF || req0_err !== 1'b0) begin
            failures++; $display("FAIL divu_by_zero cyc=%0d res=%h err=%b want 4 ffffffff 0", cyc, req0_result, req0_err);
        end
    endtask

    task automatic test_arbitration();
        int cyc, exp_id;
        logic [31:0] got;
        apply_reset();
        for (int g = 0; g < 4; g++) begin
            @(negedge CLK);
            req0_valid = 1'b1; req0_op = 5'd21; req0_a = 32'd100; req0_b = 32'd7;
            req1_valid = 1'b1; req1_op = 5'd22; req1_a = 32'd100; req1_b = 32'd7;
            exp_id = g % 2;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((exp_id == 0) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL grant%0d got=%b want=%b", g, {req0_ready, req1_ready}, (exp_id == 0) ? 2'b10 : 2'b01);
            end
            @(posedge CLK);
            wait_done(exp_id, 80, cyc);
            got = (exp_id == 0) ? req0_result : req1_result;
            checks++;
            if (cyc != 36 || got !== ((exp_id == 0) ? 32'd14 : 32'd2)) begin
                failures++; $display("FAIL arb_result%0d cyc=%0d res=%0d want cyc=36 res=%0d", g, cyc, got, (exp_id == 0) ? 14 : 2);
            end
            checks++;
            if (other_done_seen !== 1'b0 || ready_seen !== 1'b0) begin
                failures++; $display("FAIL arb_isolation%0d other_done=%b ready=%b want 0 0", g, other_done_seen, ready_seen);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_illegal_op();
        logic rdy; int cyc;
        issue(1, 5'd5, 32'd3, 32'd4, rdy);
        wait_done(1, 10, cyc);
        checks++;
        if (rdy !== 1'b1 || cyc != 1) begin failures++; $display("FAIL illegal_timing rdy=%b cyc=%0d want 1 1", rdy, cyc); end
        checks++;
        if (req1_result !== 32'd0 || req1_err !== 1'b1) begin
            failures++; $display("FAIL illegal_result res=%h err=%b want 00000000 1", req1_result, req1_err);
        end
        checks++;
        if (aluc_seen !== 1'b0) begin failures++; $display("FAIL illegal_aluc got nonzero want 0"); end
    endtask

    task automatic test_timeout();
        logic rdy; int cyc;
        alu_stall = 1'b1;
        checks++;
        if (timeout_sticky !== 1'b0) begin failures++; $display("FAIL sticky_pre got=1 want=0"); end
        issue(0, 5'd20, 32'd100, 32'd7, rdy);
        wait_done(0, 100, cyc);
        checks++;
        if (cyc != 65) begin failures++; $display("FAIL timeout_latency got=%0d want=65", cyc); end
        checks++;
        if (req0_result !== 32'hFFFF_FFFF || req0_err !== 1'b1 || timeout_sticky !== 1'b1) begin
            failures++; $display("FAIL timeout_result res=%h err=%b sticky=%b want ffffffff 1 1", req0_result, req0_err, timeout_sticky);
        end
        repeat (5) @(negedge CLK);
        checks++;
        if (timeout_sticky !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL sticky_hold sticky=%b busy=%b want 1 0", timeout_sticky, busy);
        end
        alu_stall = 1'b0;
        apply_reset();
        checks++;
        if (timeout_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear got=1 want=0"); end
    endtask

    task automatic test_reset_mid_op();
        logic rdy; int cyc;
        issue(0, 5'd21, 32'd7, 32'd0, rdy);
        wait_done(0, 80, cyc);
        issue(0, 5'd20, 32'd1000, 32'd3, rdy);
        repeat (10) @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || alu_aluc !== 5'd20) begin failures++; $display("FAIL mid_op_busy busy=%b aluc=%0d want 1 20", busy, alu_aluc); end
        RESET = 1'b1;
        #1;
        checks++;
        if ({busy, req0_done, req0_err} !== 3'b0 || {req0_result, alu_aluc, alu_a, alu_b} !== '0) begin
            failures++; $display("FAIL mid_op_reset busy=%b done=%b res=%h aluc=%0d a=%h b=%h want all 0", busy, req0_done, req0_result, alu_aluc, alu_a, alu_b);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        wait_done(0, 40, cyc);
        checks++;
        if (cyc != 41) begin failures++; $display("FAIL spurious_done got cycle %0d want none", cyc); end
        issue(0, 5'd20, 32'd1000, 32'd3, rdy);
        wait_done(0, 80, cyc);
        checks++;
        if (cyc != 36 || req0_result !== 32'd333 || req0_err !== 1'b0) begin
            failures++; $display("FAIL post_reset_div cyc=%0d res=%0d err=%b want 36 333 0", cyc, req0_result, req0_err);
        end
    endtask

    initial begin
        test_reset();
        test_div_signed();
        test_div_by_zero();
        test_arbitration();
        test_illegal_op();
        test_timeout();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares the ALU's multi-cycle divide/remainder engine (aluc 20–23) between two requesters, e.g. the integer pipe and a debug/CSR port. Each requester uses a valid/ready handshake. The block drives the ALU's `aluc`/`A`/`B` inputs, holds them stable for the whole operation, captures `Result` on `divReady` and returns it with a one-cycle done pulse. It sits beside the ALU in the core top level.

## Interface
Parameters:
- WIDTH, 32, operand/result width (the ALU is 32-bit; other values are unsupported).
- TIMEOUT, 63, maximum WAIT cycles allowed without `divReady` before the operation is aborted.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  reset, asynchronous and active-high. The top level drives the ALU's active-low RESET from ~RESET.
- req0_valid / req1_valid  in  1  request pending; held until ready.
- req0_op / req1_op  in  5  ALU opcode (20 DIV, 21 DIVU, 22 REM, 23 REMU).
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands (dividend, divisor).
- req0_ready / req1_ready  out  1  accept strobe (combinational, IDLE only).
- req0_done / req1_done  out  1  one-cycle result-valid pulse.
- req0_result / req1_result  out  WIDTH  result, held until that requester's next done.
- req0_err / req1_err  out  1  qualifies done: illegal op or timeout.
- alu_aluc  out  5  to ALU aluc.
- alu_a / alu_b  out  WIDTH  to ALU A/B.
- alu_result  in  WIDTH  from ALU Result.
- alu_div_ready  in  1  from ALU divReady.
- busy  out  1  state != IDLE.
- timeout_sticky  out  1  set on any timeout; cleared only by RESET.

## Operation
- FSM states and transitions:
  - IDLE: accepts a request. The op is legal (20..23) → ISSUE; illegal → RESP.
  - ISSUE: lasts one cycle, then → WAIT.
  - WAIT: → RESP on alu_div_ready, or when wait_cnt reaches TIMEOUT.
  - RESP: lasts one cycle, then → IDLE.
- Arbitration: `last` pointer (reset value 1, so req0 wins first).
  - Only one requester valid: it wins.
  - Both valid: the requester != last wins.
  - `last` updates on every accept.
- Accept = reqN_valid & reqN_ready while in IDLE. On accept the block latches op, a, b and the owner id.
- ALU drive:
  - In ISSUE and WAIT, alu_aluc/alu_a/alu_b = latched values, stable every cycle. The ALU re-reads A/B during BUSY for its special cases.
  - In all other states, alu_aluc = 0 (ADD) and alu_a = alu_b = 0. This keeps the ALU from restarting after its DONE cycle.
- Capture: in WAIT with alu_div_ready = 1, latch alu_result into the owner's result register.
- Timeout: wait_cnt counts WAIT cycles (width ≥ clog2(TIMEOUT+1)). On reaching TIMEOUT: result = 32'hFFFFFFFF, err = 1, timeout_sticky is set.
- Illegal op: no ALU activity. Result = 0, err = 1.
- RESP: owner's done = 1 for exactly one cycle. err is valid with done and 0 otherwise. The non-owner's outputs are untouched.
- A new request from either side (including the same requester) can be accepted only in IDLE, i.e. the cycle after RESP.

## Timing
- Reset values: all done/err/ready = 0, results = 0, alu_aluc/alu_a/alu_b = 0, busy = 0, timeout_sticky = 0, state IDLE, last = 1.
- Reset mid-operation: immediate return to IDLE with all reset values. No done is issued, and the ALU is reset by the same net.
- Legal op cycle sequence, with accept at cycle T0:
  - ISSUE at T1; the ALU samples at the end of T1.
  - ALU BUSY T2..T34.
  - divReady at T35; captured at the end of T35.
  - done at T36, so accept→done is 36 cycles.
  - IDLE at T37.
- Divide-by-zero or 0x80000000 / 0xFFFFFFFF (DIV/REM): ALU BUSY for one cycle, divReady at T3, done at T4.
- Illegal op: accept at T0, done at T1.
- ready is never asserted outside IDLE. If both requesters are valid, exactly one ready is asserted.

## Test plan
- req0 DIV a=0xFFFFFFF9 (−7), b=2 → req0_ready at T0, req0_done at T36, req0_result = 0xFFFFFFFD, err = 0.
- req0 REMU a=7, b=0 → req0_done at T4, result = 7. DIVU a=7, b=0 → result = 0xFFFFFFFF.
- req0 and req1 both valid from reset, req0 DIVU 100/7, req1 REM 100/7:
  - req0 is granted first and gets result 14.
  - req1 is accepted the cycle after req0_done and gets result 2.
  - Repeat with both still valid: the grant alternates.
- req1 op = 5 (XOR) → req1_done at T1, result 0, err = 1; alu_aluc stays 0 throughout.
- Stub ALU with divReady tied 0, TIMEOUT = 63 → done at T0+65, result 0xFFFFFFFF, err = 1, timeout_sticky = 1 until RESET.
- RESET asserted at T10 of a DIV → all outputs 0 immediately, no done pulse. A new request after release completes normally.
